// File: rtl/rib_pkg.sv
// Shared constants for the RIB master arbiter: arbitration modes and the
// width of a master ID.
package rib_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // A master ID needs at least one bit even for a single master.
    function automatic int rib_id_w(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/rib_id_fifo.sv
// In-order FIFO of master IDs for transactions that were accepted by the
// slave but have not yet been answered.
module rib_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty/count decide whether the head is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rib_master_arbiter.sv
// N-master to 1-slave RIB arbiter: round-robin or fixed-priority request
// selection, in-order response routing through an ID FIFO.
module rib_master_arbiter
    import rib_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 2,
    parameter int ARB_MODE    = 0
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_MASTERS*AW-1:0]          i_m_addr,
    input  logic [NUM_MASTERS-1:0]             i_m_wrcs,
    input  logic [NUM_MASTERS*DW/8-1:0]        i_m_mask,
    input  logic [NUM_MASTERS*DW-1:0]          i_m_wdata,
    input  logic [NUM_MASTERS-1:0]             i_m_req,
    output logic [NUM_MASTERS-1:0]             o_m_gnt,
    output logic [NUM_MASTERS*DW-1:0]          o_m_rdata,
    output logic [NUM_MASTERS-1:0]             o_m_rsp,
    input  logic [NUM_MASTERS-1:0]             i_m_rdy,
    output logic [AW-1:0]                      o_s_addr,
    output logic                               o_s_wrcs,
    output logic [DW/8-1:0]                    o_s_mask,
    output logic [DW-1:0]                      o_s_wdata,
    output logic                               o_s_req,
    input  logic                               i_s_gnt,
    input  logic [DW-1:0]                      i_s_rdata,
    input  logic                               i_s_rsp,
    output logic                               o_s_rdy,
    output logic [$clog2(OUTSTANDING+1)-1:0]   o_outstanding,
    output logic                               o_err
);

    localparam int IDW = rib_id_w(NUM_MASTERS);
    localparam int MW  = DW / 8;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] head;
    logic           found;
    int             idx;
    logic           accept;
    logic           pop;
    logic           full;
    logic           empty;

    // Winner search: scan from rr_ptr with wrap in round-robin mode,
    // from index 0 in fixed-priority mode.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ARB_MODE == ARB_FIXED) idx = i;
            else                       idx = (int'(rr_ptr) + i) % NUM_MASTERS;
            if (!found && i_m_req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign o_s_addr  = i_m_addr[int'(winner)*AW +: AW];
    assign o_s_wrcs  = i_m_wrcs[winner];
    assign o_s_mask  = i_m_mask[int'(winner)*MW +: MW];
    assign o_s_wdata = i_m_wdata[int'(winner)*DW +: DW];

    // A full FIFO blocks requests even when a pop lands in the same cycle.
    assign o_s_req   = (|i_m_req) & ~full;
    assign accept    = o_s_req & i_s_gnt;
    assign o_s_rdy   = ~empty & i_m_rdy[head];
    assign pop       = i_s_rsp & o_s_rdy;
    assign o_m_rdata = {NUM_MASTERS{i_s_rdata}};

    always_comb begin
        o_m_gnt = '0;
        o_m_rsp = '0;
        if (accept) o_m_gnt[winner] = 1'b1;
        if (!empty) o_m_rsp[head]   = i_s_rsp;
    end

    rib_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (accept),
        .push_data (winner),
        .pop       (pop),
        .head      (head),
        .count     (o_outstanding),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr <= '0;
            o_err  <= 1'b0;
        end else begin
            if (accept && ARB_MODE == ARB_RR)
                rr_ptr <= (winner == IDW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
            if (i_s_rsp && empty)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rib_master_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share
// stimulus and are each compared against a queue-based reference model.
module tb_rib_master_arbiter;
    import rib_pkg::*;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int OUT = 2;
    localparam int CW  = $clog2(OUT + 1);

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N*AW-1:0] i_m_addr;
    logic [N-1:0]    i_m_wrcs;
    logic [N*MW-1:0] i_m_mask;
    logic [N*DW-1:0] i_m_wdata;
    logic [N-1:0]    i_m_req;
    logic [N-1:0]    i_m_rdy;
    logic            i_s_gnt;
    logic [DW-1:0]   i_s_rdata;
    logic            i_s_rsp;

    logic [N-1:0]    o_gnt   [2];
    logic [N*DW-1:0] o_rdata [2];
    logic [N-1:0]    o_rsp   [2];
    logic [AW-1:0]   o_addr  [2];
    logic            o_wrcs  [2];
    logic [MW-1:0]   o_mask  [2];
    logic [DW-1:0]   o_wdata [2];
    logic            o_sreq  [2];
    logic            o_srdy  [2];
    logic [CW-1:0]   o_out   [2];
    logic            o_errf  [2];

    rib_master_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .OUTSTANDING(OUT), .ARB_MODE(ARB_RR)) dut_rr (
        .i_clk(i_clk), .i_rst(i_rst), .i_m_addr(i_m_addr), .i_m_wrcs(i_m_wrcs),
        .i_m_mask(i_m_mask), .i_m_wdata(i_m_wdata), .i_m_req(i_m_req), .o_m_gnt(o_gnt[0]),
        .o_m_rdata(o_rdata[0]), .o_m_rsp(o_rsp[0]), .i_m_rdy(i_m_rdy), .o_s_addr(o_addr[0]),
        .o_s_wrcs(o_wrcs[0]), .o_s_mask(o_mask[0]), .o_s_wdata(o_wdata[0]), .o_s_req(o_sreq[0]),
        .i_s_gnt(i_s_gnt), .i_s_rdata(i_s_rdata), .i_s_rsp(i_s_rsp), .o_s_rdy(o_srdy[0]),
        .o_outstanding(o_out[0]), .o_err(o_errf[0])
    );

    rib_master_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .OUTSTANDING(OUT), .ARB_MODE(ARB_FIXED)) dut_fx (
        .i_clk(i_clk), .i_rst(i_rst), .i_m_addr(i_m_addr), .i_m_wrcs(i_m_wrcs),
        .i_m_mask(i_m_mask), .i_m_wdata(i_m_wdata), .i_m_req(i_m_req), .o_m_gnt(o_gnt[1]),
        .o_m_rdata(o_rdata[1]), .o_m_rsp(o_rsp[1]), .i_m_rdy(i_m_rdy), .o_s_addr(o_addr[1]),
        .o_s_wrcs(o_wrcs[1]), .o_s_mask(o_mask[1]), .o_s_wdata(o_wdata[1]), .o_s_req(o_sreq[1]),
        .i_s_gnt(i_s_gnt), .i_s_rdata(i_s_rdata), .i_s_rsp(i_s_rsp), .o_s_rdy(o_srdy[1]),
        .o_outstanding(o_out[1]), .o_err(o_errf[1])
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int passes = 0;

    // Reference model: per-DUT list of owner IDs in acceptance order.
    int mq    [2][OUT];
    int mcnt  [2];
    int mrr   [2];
    bit merr  [2];
    int mmode [2];

    logic [N-1:0]    obs_gnt  [2];
    logic [N-1:0]    obs_rsp  [2];
    logic            obs_sreq [2];
    logic            obs_srdy [2];
    logic [CW-1:0]   obs_out  [2];
    logic            obs_err  [2];

    logic [N*AW-1:0] nxt_addr;
    logic [N*MW-1:0] nxt_mask;
    logic [N*DW-1:0] nxt_wdata;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int expWinner(input int d, input logic [N-1:0] req);
        if (mmode[d] == ARB_FIXED) begin
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int i = 0; i < N; i++) if (req[(mrr[d] + i) % N]) return (mrr[d] + i) % N;
        end
        return -1;
    endfunction

    function automatic void resetModel();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            mrr[d]  = 0;
            merr[d] = 1'b0;
        end
    endfunction

    // Drive one cycle after the falling edge, compare, then advance the model.
    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] wrcs,
                                 input logic sgnt, input logic srsp,
                                 input logic [N-1:0] rdy, input logic [DW-1:0] rdata);
        int w, h;
        logic sreq, acc, erdy;
        logic [N-1:0] egnt, ersp;
        @(negedge i_clk);
        i_m_req   = req;
        i_m_wrcs  = wrcs;
        i_s_gnt   = sgnt;
        i_s_rsp   = srsp;
        i_m_rdy   = rdy;
        i_s_rdata = rdata;
        i_m_addr  = nxt_addr;
        i_m_mask  = nxt_mask;
        i_m_wdata = nxt_wdata;
        #1;
        for (int d = 0; d < 2; d++) begin
            obs_gnt[d]  = o_gnt[d];
            obs_rsp[d]  = o_rsp[d];
            obs_sreq[d] = o_sreq[d];
            obs_srdy[d] = o_srdy[d];
            obs_out[d]  = o_out[d];
            obs_err[d]  = o_errf[d];
            w    = expWinner(d, req);
            sreq = (req != '0) && (mcnt[d] < OUT);
            acc  = sreq && sgnt;
            egnt = acc ? N'(1 << w) : '0;
            h    = (mcnt[d] > 0) ? mq[d][0] : 0;
            ersp = (mcnt[d] > 0 && srsp) ? N'(1 << h) : '0;
            erdy = (mcnt[d] > 0) && rdy[h];
            checkOutput($sformatf("s_req%0d", d), 64'(o_sreq[d]), 64'(sreq));
            checkOutput($sformatf("gnt%0d", d), 64'(o_gnt[d]), 64'(egnt));
            checkOutput($sformatf("rsp%0d", d), 64'(o_rsp[d]), 64'(ersp));
            checkOutput($sformatf("s_rdy%0d", d), 64'(o_srdy[d]), 64'(erdy));
            checkOutput($sformatf("outstanding%0d", d), 64'(o_out[d]), 64'(mcnt[d]));
            checkOutput($sformatf("err%0d", d), 64'(o_errf[d]), 64'(merr[d]));
            for (int k = 0; k < N; k++)
                checkOutput($sformatf("rdata%0d_m%0d", d, k), 64'(o_rdata[d][k*DW +: DW]), 64'(rdata));
            if (w >= 0) begin
                checkOutput($sformatf("s_addr%0d", d), 64'(o_addr[d]), 64'(nxt_addr[w*AW +: AW]));
                checkOutput($sformatf("s_wrcs%0d", d), 64'(o_wrcs[d]), 64'(wrcs[w]));
                checkOutput($sformatf("s_mask%0d", d), 64'(o_mask[d]), 64'(nxt_mask[w*MW +: MW]));
                checkOutput($sformatf("s_wdata%0d", d), 64'(o_wdata[d]), 64'(nxt_wdata[w*DW +: DW]));
            end
            if (srsp && mcnt[d] == 0) merr[d] = 1'b1;
            if (srsp && erdy) begin
                for (int i = 0; i < OUT - 1; i++) mq[d][i] = mq[d][i+1];
                mcnt[d]--;
            end
            if (acc) begin
                mq[d][mcnt[d]] = w;
                mcnt[d]++;
                if (mmode[d] == ARB_RR) mrr[d] = (w + 1) % N;
            end
        end
    endtask

    task automatic applyReset();
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_m_req = '0;
        i_s_gnt = 1'b0;
        i_s_rsp = 1'b0;
        i_m_rdy = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst_out%0d", d), 64'(o_out[d]), 64'd0);
            checkOutput($sformatf("rst_err%0d", d), 64'(o_errf[d]), 64'd0);
            checkOutput($sformatf("rst_rsp%0d", d), 64'(o_rsp[d]), 64'd0);
        end
        #2;
        i_rst = 1'b0;
        resetModel();
    endtask

    initial begin
        logic [N-1:0] rr_pat [4];
        rr_pat[0] = 2'b01; rr_pat[1] = 2'b10; rr_pat[2] = 2'b01; rr_pat[3] = 2'b10;
        mmode[0] = ARB_RR;
        mmode[1] = ARB_FIXED;
        resetModel();
        nxt_addr  = {32'h0000_0200, 32'h0000_0100};
        nxt_mask  = 8'hF3;
        nxt_wdata = {32'hB0B0_B0B0, 32'hA0A0_A0A0};
        i_m_addr = nxt_addr; i_m_mask = nxt_mask; i_m_wdata = nxt_wdata;
        i_m_wrcs = '0; i_m_req = '0; i_m_rdy = '0;
        i_s_gnt = 1'b0; i_s_rsp = 1'b0; i_s_rdata = '0;
        i_rst = 1'b1;
        #12;
        i_rst = 1'b0;

        // Single master read of 0x100 answered two cycles later.
        applyReset();
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0);
        checkOutput("single_gnt", 64'(obs_gnt[0]), 64'h1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("single_out1", 64'(obs_out[0]), 64'd1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 32'hDEAD_BEEF);
        checkOutput("single_rsp", 64'(obs_rsp[0]), 64'h1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("single_out0", 64'(obs_out[0]), 64'd0);

        // Continuous contention with one push and one pop per cycle.
        applyReset();
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 32'h0);
        checkOutput("rr_alt0", 64'(obs_gnt[0]), 64'(rr_pat[0]));
        checkOutput("fx_alt0", 64'(obs_gnt[1]), 64'h1);
        for (int c = 1; c < 4; c++) begin
            applyStimulus(2'b11, 2'b00, 1'b1, 1'b1, 2'b11, 32'h5A);
            checkOutput($sformatf("rr_alt%0d", c), 64'(obs_gnt[0]), 64'(rr_pat[c]));
            checkOutput($sformatf("fx_alt%0d", c), 64'(obs_gnt[1]), 64'h1);
        end

        // Outstanding limit: full blocks even when a pop happens that cycle.
        applyReset();
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 32'h0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 32'h0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 32'h0);
        checkOutput("full_sreq", 64'(obs_sreq[0]), 64'd0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b1, 2'b11, 32'h1);
        checkOutput("full_pop_sreq", 64'(obs_sreq[0]), 64'd0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 32'h0);
        checkOutput("full_after_gnt", 64'(obs_gnt[0]), 64'h1);

        // In-order routing of two responses, M1 first.
        applyReset();
        applyStimulus(2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 32'h0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 32'h11);
        checkOutput("order_hold_rdy", 64'(obs_srdy[0]), 64'd0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 32'h11);
        checkOutput("order_rsp1", 64'(obs_rsp[0]), 64'h2);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 32'h22);
        checkOutput("order_rsp2", 64'(obs_rsp[0]), 64'h1);

        // Spurious response while empty sets the sticky error.
        applyReset();
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 32'h0);
        checkOutput("spur_rsp", 64'(obs_rsp[0]), 64'd0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
        checkOutput("spur_err", 64'(obs_err[0]), 64'd1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
        checkOutput("spur_sticky", 64'(obs_err[0]), 64'd1);
        applyReset();

        // Asynchronous reset between edges with two transactions in flight.
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0);
        @(negedge i_clk);
        i_m_req = '0; i_s_gnt = 1'b0; i_s_rsp = 1'b1; i_m_rdy = 2'b11;
        #2;
        i_rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("async_out%0d", d), 64'(o_out[d]), 64'd0);
            checkOutput($sformatf("async_rsp%0d", d), 64'(o_rsp[d]), 64'd0);
        end
        i_s_rsp = 1'b0;
        #1;
        i_rst = 1'b0;
        resetModel();
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0);
        checkOutput("async_rr_restart", 64'(obs_gnt[0]), 64'h1);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic srsp;
            if (c == 200) applyReset();
            nxt_addr  = {$urandom, $urandom};
            nxt_mask  = 8'($urandom);
            nxt_wdata = {$urandom, $urandom};
            if (mcnt[0] > 0 && mcnt[1] > 0) srsp = 1'($urandom_range(0, 1));
            else                            srsp = ($urandom_range(0, 40) == 0);
            applyStimulus(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0), srsp,
                          ($urandom_range(0, 3) != 0) ? 2'b11 : N'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
